// File: rtl/reconfig_pkg.sv
// Shared constants, status codes and FSM states for the reboot request front end.
// Purely declarative: no latency, no backpressure.
// The timer-load helper turns a cycle count into a down-counter preload.
package reconfig_pkg;

  localparam logic [7:0] KEY_BYTE = 8'hA5;

  localparam logic [1:0] STATUS_OK       = 2'd0;
  localparam logic [1:0] STATUS_CHK_ERR  = 2'd1;
  localparam logic [1:0] STATUS_ADDR_ERR = 2'd2;
  localparam logic [1:0] STATUS_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CHK,
    VERIFY,
    DELAY,
    ISSUE,
    WAIT
  } state_t;

  // The timer expires when it reaches zero, so N cycles needs a preload of N-1.
  function automatic logic [31:0] timer_load(input int unsigned cycles);
    return (cycles == 0) ? 32'd0 : 32'(cycles - 1);
  endfunction

endpackage

// File: rtl/reconfig_timer.sv
// Loadable 32-bit down-counter shared by the settle, DONE and inter-byte timeouts.
// Latency: load takes effect next cycle; expired is a decode of the count.
// No backpressure: counts while enabled, saturates at zero.
module reconfig_timer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        en,
  output logic        expired
);

  logic [31:0] count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 32'd1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/reconfig_request_ctrl.sv
// Framed reboot-request receiver: checks key/address/checksum, waits, strobes ICAP, supervises DONE.
// Latency: CHK byte at T, status at T+1 on error, VALID_O at T+2+DELAY_CYCLES.
// Backpressure: BYTE_READY_O only in IDLE/ADDR/CHK; bytes offered otherwise are dropped.
module reconfig_request_ctrl
  import reconfig_pkg::*;
#(
  parameter logic [31:0] FLASH_SIZE   = 32'h0200_0000,
  parameter int unsigned DELAY_CYCLES = 1000,
  parameter int unsigned DONE_TIMEOUT = 65535,
  parameter int unsigned BYTE_TIMEOUT = 4095
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  BYTE_I,
  input  logic        BYTE_VALID_I,
  output logic        BYTE_READY_O,
  output logic [31:0] ADDRESS_O,
  output logic        VALID_O,
  input  logic        DONE_I,
  output logic        BUSY_O,
  output logic [1:0]  STATUS_O,
  output logic        STATUS_VALID_O
);

  state_t      state, state_nxt;
  logic [31:0] addr_sh;
  logic [31:0] addr_q;
  logic [7:0]  chk_acc;
  logic [7:0]  chk_rx;
  logic [1:0]  byte_cnt;
  logic        valid_q;
  logic [1:0]  status_q;
  logic        xfer;
  logic        chk_ok;
  logic        addr_ok;
  logic        tmr_load;
  logic [31:0] tmr_val;
  logic        tmr_en;
  logic        tmr_exp;
  logic        st_pulse;
  logic [1:0]  st_code;

  assign BYTE_READY_O = !RST && ((state == IDLE) || (state == ADDR) || (state == CHK));
  assign xfer         = BYTE_VALID_I && BYTE_READY_O;
  assign chk_ok       = (chk_rx == chk_acc);
  assign addr_ok      = (addr_sh[7:0] == 8'h00) && (addr_sh < FLASH_SIZE);

  reconfig_timer u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expired  (tmr_exp)
  );

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_en    = 1'b0;
    st_pulse  = 1'b0;
    st_code   = STATUS_OK;
    case (state)
      IDLE: begin
        if (xfer && (BYTE_I == KEY_BYTE)) begin
          state_nxt = ADDR;
          tmr_load  = 1'b1;
          tmr_val   = timer_load(BYTE_TIMEOUT);
        end
      end
      ADDR: begin
        tmr_en = 1'b1;
        if (xfer) begin
          tmr_load = 1'b1;
          tmr_val  = timer_load(BYTE_TIMEOUT);
          if (byte_cnt == 2'd3) state_nxt = CHK;
        end else if (tmr_exp) begin
          state_nxt = IDLE;
          st_pulse  = 1'b1;
          st_code   = STATUS_TIMEOUT;
        end
      end
      CHK: begin
        tmr_en = 1'b1;
        if (xfer) begin
          state_nxt = VERIFY;
        end else if (tmr_exp) begin
          state_nxt = IDLE;
          st_pulse  = 1'b1;
          st_code   = STATUS_TIMEOUT;
        end
      end
      VERIFY: begin
        if (!chk_ok) begin
          state_nxt = IDLE;
          st_pulse  = 1'b1;
          st_code   = STATUS_CHK_ERR;
        end else if (!addr_ok) begin
          state_nxt = IDLE;
          st_pulse  = 1'b1;
          st_code   = STATUS_ADDR_ERR;
        end else if (DELAY_CYCLES == 0) begin
          state_nxt = ISSUE;
        end else begin
          state_nxt = DELAY;
          tmr_load  = 1'b1;
          tmr_val   = timer_load(DELAY_CYCLES);
        end
      end
      DELAY: begin
        tmr_en = 1'b1;
        if (tmr_exp) state_nxt = ISSUE;
      end
      ISSUE: begin
        state_nxt = WAIT;
        tmr_load  = 1'b1;
        tmr_val   = timer_load(DONE_TIMEOUT);
      end
      WAIT: begin
        tmr_en = 1'b1;
        // DONE wins over a coincident timeout expiry.
        if (DONE_I) begin
          state_nxt = IDLE;
          st_pulse  = 1'b1;
          st_code   = STATUS_OK;
        end else if (tmr_exp) begin
          state_nxt = IDLE;
          st_pulse  = 1'b1;
          st_code   = STATUS_TIMEOUT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      addr_sh  <= '0;
      addr_q   <= '0;
      chk_acc  <= '0;
      chk_rx   <= '0;
      byte_cnt <= '0;
      valid_q  <= 1'b0;
      status_q <= STATUS_OK;
    end else begin
      state   <= state_nxt;
      valid_q <= (state_nxt == ISSUE);
      if (st_pulse) status_q <= st_code;
      if ((state == IDLE) && xfer) begin
        chk_acc  <= '0;
        byte_cnt <= '0;
      end
      if ((state == ADDR) && xfer) begin
        addr_sh  <= {addr_sh[23:0], BYTE_I};
        chk_acc  <= chk_acc ^ BYTE_I;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if ((state == CHK) && xfer) chk_rx <= BYTE_I;
      if ((state == VERIFY) && chk_ok && addr_ok) addr_q <= addr_sh;
    end
  end

  // Status is reported in the same cycle as the return to IDLE, so it bypasses its hold register.
  assign STATUS_VALID_O = st_pulse && !RST;
  assign STATUS_O       = STATUS_VALID_O ? st_code : status_q;
  assign VALID_O        = valid_q;
  assign ADDRESS_O      = addr_q;
  assign BUSY_O         = (state == DELAY) || (state == ISSUE) || (state == WAIT);

endmodule

// File: tb/tb_reconfig_request_ctrl.sv
// Scoreboard bench: expected status codes are queued per frame and popped on STATUS_VALID_O.
module tb_reconfig_request_ctrl;

  localparam int DLY = 4;
  localparam int DTO = 20;
  localparam int BTO = 10;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  BYTE_I;
  logic        BYTE_VALID_I;
  logic        BYTE_READY_O;
  logic [31:0] ADDRESS_O;
  logic        VALID_O;
  logic        DONE_I;
  logic        BUSY_O;
  logic [1:0]  STATUS_O;
  logic        STATUS_VALID_O;

  always #5 CLK = ~CLK;

  reconfig_request_ctrl #(
    .FLASH_SIZE   (32'h0200_0000),
    .DELAY_CYCLES (DLY),
    .DONE_TIMEOUT (DTO),
    .BYTE_TIMEOUT (BTO)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .BYTE_I         (BYTE_I),
    .BYTE_VALID_I   (BYTE_VALID_I),
    .BYTE_READY_O   (BYTE_READY_O),
    .ADDRESS_O      (ADDRESS_O),
    .VALID_O        (VALID_O),
    .DONE_I         (DONE_I),
    .BUSY_O         (BUSY_O),
    .STATUS_O       (STATUS_O),
    .STATUS_VALID_O (STATUS_VALID_O)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int valid_cnt   = 0;
  int valid_cyc   = -1;
  int status_cnt  = 0;
  int status_cyc  = -1;
  logic [1:0] exp_q[$];

  logic        ready_s, valid_s, busy_s, svld_s;
  logic [31:0] addr_s;
  logic [1:0]  status_s;

  // One clock: drive just after the edge, sample on the falling edge.
  task automatic step(input logic [7:0] b, input logic bv, input logic done, input logic rst);
    logic [1:0] e;
    @(posedge CLK);
    #1;
    BYTE_I = b; BYTE_VALID_I = bv; DONE_I = done; RST = rst;
    cyc++;
    @(negedge CLK);
    ready_s = BYTE_READY_O; valid_s = VALID_O; busy_s = BUSY_O;
    svld_s = STATUS_VALID_O; addr_s = ADDRESS_O; status_s = STATUS_O;
    if (valid_s) begin valid_cnt++; valid_cyc = cyc; end
    if (svld_s) begin
      status_cnt++; status_cyc = cyc; vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_status cyc %0d: got STATUS_O=%0d, expected no pulse", cyc, status_s);
      end else begin
        e = exp_q.pop_front();
        if (status_s !== e) begin
          miscompares++;
          $display("FAIL status_code cyc %0d: got %0d, expected %0d", cyc, status_s, e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [31:0] addr, input logic [7:0] chk);
    logic [7:0] bytes [6];
    bytes[0] = 8'hA5; bytes[1] = addr[31:24]; bytes[2] = addr[23:16];
    bytes[3] = addr[15:8]; bytes[4] = addr[7:0]; bytes[5] = chk;
    for (int i = 0; i < 6; i++) begin
      step(bytes[i], 1'b1, 1'b0, 1'b0);
      vectors++;
      if (ready_s !== 1'b1) begin
        miscompares++;
        $display("FAIL byte_accept[%0d] cyc %0d: ready=%b, expected 1", i, cyc, ready_s);
      end
    end
  endtask

  task automatic wait_valid(input int max);
    int start;
    start = valid_cnt;
    for (int i = 0; i < max && valid_cnt == start; i++) idle(1);
    vectors++;
    if (valid_cnt == start) begin
      miscompares++;
      $display("FAIL valid_wait: no VALID_O within %0d cycles, expected one", max);
    end
  endtask

  task automatic wait_status(input int max);
    int start;
    start = status_cnt;
    for (int i = 0; i < max && status_cnt == start; i++) idle(1);
    vectors++;
    if (status_cnt == start) begin
      miscompares++;
      $display("FAIL status_wait: no STATUS_VALID_O within %0d cycles, expected one", max);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; BYTE_I = '0; BYTE_VALID_I = 1'b0; DONE_I = 1'b0;
    step(8'h00, 1'b0, 1'b0, 1'b1);
    step(8'hA5, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (ready_s !== 1'b0) begin miscompares++; $display("FAIL reset_ready_in_rst: got %b, expected 0", ready_s); end
    idle(1);
    vectors++;
    if (ready_s !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after: got %b, expected 1", ready_s); end
    vectors++;
    if ({valid_s, busy_s, svld_s} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: got valid/busy/svld=%b, expected 000", {valid_s, busy_s, svld_s});
    end
    vectors++;
    if (addr_s !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h, expected 0", addr_s); end
    vectors++;
    if (status_s !== 2'd0) begin miscompares++; $display("FAIL reset_status: got %0d, expected 0", status_s); end
  endtask

  task automatic test_ok();
    int t;
    exp_q.push_back(2'd0);
    send_frame(32'h0012_3400, 8'h26);
    t = cyc;
    wait_valid(30);
    vectors++;
    if (valid_cyc !== t + 2 + DLY) begin miscompares++; $display("FAIL ok_valid_cycle: got %0d, expected %0d", valid_cyc - t, 2 + DLY); end
    vectors++;
    if (addr_s !== 32'h0012_3400) begin miscompares++; $display("FAIL ok_address: got %h, expected 00123400", addr_s); end
    idle(2);
    step(8'h00, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (status_cyc !== cyc || busy_s !== 1'b1) begin
      miscompares++; $display("FAIL ok_done_pulse: pulse cyc %0d busy %b, expected cyc %0d busy 1", status_cyc, busy_s, cyc);
    end
    idle(1);
    vectors++;
    if (busy_s !== 1'b0 || status_s !== 2'd0) begin
      miscompares++; $display("FAIL ok_after: busy %b status %0d, expected busy 0 status 0", busy_s, status_s);
    end
    vectors++;
    if (valid_cnt !== 1) begin miscompares++; $display("FAIL ok_valid_count: got %0d, expected 1", valid_cnt); end
  endtask

  task automatic test_chk_err();
    int t, vc;
    vc = valid_cnt;
    exp_q.push_back(2'd1);
    send_frame(32'h0012_3400, 8'h27);
    t = cyc;
    idle(1);
    vectors++;
    if (status_cyc !== t + 1) begin miscompares++; $display("FAIL chk_err_timing: got T+%0d, expected T+1", status_cyc - t); end
    idle(8);
    vectors++;
    if (valid_cnt !== vc) begin miscompares++; $display("FAIL chk_err_valid: got %0d strobes, expected 0", valid_cnt - vc); end
    vectors++;
    if (status_s !== 2'd1 || addr_s !== 32'h0012_3400 || ready_s !== 1'b1) begin
      miscompares++; $display("FAIL chk_err_hold: status %0d addr %h ready %b, expected 1 00123400 1", status_s, addr_s, ready_s);
    end
  endtask

  task automatic test_addr_err_back_to_back();
    int t, vc;
    vc = valid_cnt;
    exp_q.push_back(2'd2);
    send_frame(32'h0012_3480, 8'hA6);
    t = cyc;
    idle(1);
    vectors++;
    if (status_cyc !== t + 1) begin miscompares++; $display("FAIL align_err_timing: got T+%0d, expected T+1", status_cyc - t); end
    exp_q.push_back(2'd2);
    send_frame(32'h0200_0000, 8'h02);
    t = cyc;
    idle(1);
    vectors++;
    if (status_cyc !== t + 1) begin miscompares++; $display("FAIL range_err_timing: got T+%0d, expected T+1", status_cyc - t); end
    vectors++;
    if (valid_cnt !== vc || addr_s !== 32'h0012_3400) begin
      miscompares++; $display("FAIL addr_err_side: strobes %0d addr %h, expected 0 00123400", valid_cnt - vc, addr_s);
    end
  endtask

  task automatic test_done_timeout();
    int t, v, start;
    exp_q.push_back(2'd3);
    send_frame(32'h0100_0000, 8'h01);
    t = cyc;
    // DONE held through DELAY and ISSUE must be ignored.
    for (int i = 0; i < 2 + DLY; i++) step(8'h00, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (valid_cyc !== t + 2 + DLY) begin miscompares++; $display("FAIL to_valid_cycle: got T+%0d, expected T+%0d", valid_cyc - t, 2 + DLY); end
    v = valid_cyc;
    start = status_cnt;
    for (int i = 0; i < DTO + 10 && status_cnt == start; i++) begin
      step(8'hA5, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (ready_s !== 1'b0) begin miscompares++; $display("FAIL wait_drop cyc %0d: ready %b, expected 0", cyc, ready_s); end
    end
    vectors++;
    if (status_cyc !== v + DTO) begin miscompares++; $display("FAIL done_timeout_cycle: got ISSUE+%0d, expected ISSUE+%0d", status_cyc - v, DTO); end
    idle(1);
    vectors++;
    if (ready_s !== 1'b1 || busy_s !== 1'b0 || status_s !== 2'd3) begin
      miscompares++; $display("FAIL to_after: ready %b busy %b status %0d, expected 1 0 3", ready_s, busy_s, status_s);
    end
  endtask

  task automatic test_done_at_expiry();
    int v;
    exp_q.push_back(2'd0);
    send_frame(32'h0100_0000, 8'h01);
    wait_valid(30);
    v = valid_cyc;
    idle(DTO - 1);
    step(8'h00, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (status_cyc !== v + DTO) begin miscompares++; $display("FAIL tie_cycle: got ISSUE+%0d, expected ISSUE+%0d", status_cyc - v, DTO); end
    step(8'h00, 1'b0, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic test_byte_timeout();
    int l;
    step(8'h00, 1'b1, 1'b0, 1'b0);
    step(8'hFF, 1'b1, 1'b0, 1'b0);
    idle(1);
    vectors++;
    if (ready_s !== 1'b1 || busy_s !== 1'b0) begin
      miscompares++; $display("FAIL garbage_idle: ready %b busy %b, expected 1 0", ready_s, busy_s);
    end
    exp_q.push_back(2'd3);
    step(8'hA5, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    step(8'h12, 1'b1, 1'b0, 1'b0);
    l = cyc;
    wait_status(BTO + 10);
    vectors++;
    if (status_cyc !== l + BTO) begin miscompares++; $display("FAIL byte_timeout_cycle: got L+%0d, expected L+%0d", status_cyc - l, BTO); end
    idle(1);
    vectors++;
    if (ready_s !== 1'b1) begin miscompares++; $display("FAIL byte_timeout_idle: ready %b, expected 1", ready_s); end
  endtask

  task automatic test_rst_delay();
    int t, vc;
    vc = valid_cnt;
    send_frame(32'h0012_3400, 8'h26);
    idle(2);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (ready_s !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b, expected 0", ready_s); end
    idle(1);
    vectors++;
    if ({ready_s, busy_s, valid_s, svld_s} !== 4'b1000 || status_s !== 2'd0 || addr_s !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_outputs: ready/busy/valid/svld=%b status %0d addr %h, expected 1000 0 0",
               {ready_s, busy_s, valid_s, svld_s}, status_s, addr_s);
    end
    idle(15);
    vectors++;
    if (valid_cnt !== vc) begin miscompares++; $display("FAIL rst_no_valid: got %0d strobes, expected 0", valid_cnt - vc); end
    exp_q.push_back(2'd0);
    send_frame(32'h0100_0000, 8'h01);
    t = cyc;
    wait_valid(30);
    vectors++;
    if (valid_cyc !== t + 2 + DLY || addr_s !== 32'h0100_0000) begin
      miscompares++; $display("FAIL rst_recover: valid T+%0d addr %h, expected T+%0d 01000000", valid_cyc - t, addr_s, 2 + DLY);
    end
    step(8'h00, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (status_cyc !== cyc) begin miscompares++; $display("FAIL rst_recover_done: pulse cyc %0d, expected %0d", status_cyc, cyc); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_ok();
    test_chk_err();
    test_addr_err_back_to_back();
    test_done_timeout();
    test_done_at_expiry();
    test_byte_timeout();
    test_rst_delay();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain: %0d expected statuses never reported, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
